div_sequencer: RTL and testbench

Multi-cycle sequencer and datapath for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU), attached to the EX stage beside the single-cycle ALU. It accepts one operation from EX and runs 32 radix-2 restoring iterations, then a sign-fix step. While it works it holds a stall request to the pipeline controller, and it returns the result on a one-cycle done pulse. Special operands (divide-by-zero, signed overflow) produce exactly the values the RISC-V spec requires.

---
 rtl/div_sequencer_pkg.sv | 31 +++
 rtl/div_sequencer_step.sv | 36 +++
 rtl/div_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_div_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg
// Shared types and constants for the RV32M divide/remainder sequencer.
//   div_state_e      : sequencer FSM state encoding (IDLE, CALC, FIX, DONE)
//   F3_*             : func3 encodings of the four M-extension divide ops
//   DIV_OVF_DIVIDEND : most-negative 32-bit value, the signed-overflow dividend
//   is_signed_op()   : true for DIV/REM, which operate on two's-complement values
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    function automatic logic is_signed_op(input logic [2:0] f3);
        case (f3)
            F3_DIV, F3_REM:   is_signed_op = 1'b1;
            F3_DIVU, F3_REMU: is_signed_op = 1'b0;
            default:          is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// div_step
// One radix-2 restoring division iteration, purely combinational.
// Shifts {rem, quo} left by one, and if the shifted remainder is at least
// the divisor, subtracts the divisor and sets the new quotient LSB.
//   rem_i / quo_i : current partial remainder / quotient (dividend bits shift out of quo)
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : values after this iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs XLEN+1 bits: rem < divisor, so 2*rem+1 may exceed XLEN bits.
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN-1:0] diff_s;

    // Shift, compare and conditionally subtract.
    always_comb begin
        rem_sh_s = {rem_i, quo_i[XLEN-1]};
        // When the subtraction is taken the true difference is < divisor, so the low XLEN bits suffice.
        diff_s   = rem_sh_s[XLEN-1:0] - dvs_i;
        if (rem_sh_s >= {1'b0, dvs_i}) begin
            rem_o = diff_s;
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = rem_sh_s[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit beside the EX-stage ALU.
// Operands are latched as magnitudes, XLEN restoring iterations run in CALC,
// FIX restores signs and applies the RISC-V divide-by-zero / overflow results,
// and DONE presents the result with a one-cycle done pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : valid divide op from EX, sampled only in IDLE
//   func3    : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend : rs1 value, divisor : rs2 value (latched on accept)
//   flush    : kills the operation in flight, masks start
//   busy     : stall request to the pipeline controller
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until the next completed op
// Build option: define DIV_FASTPATH_EN to resolve divide-by-zero and signed
// overflow directly from IDLE to DONE (done one cycle after accept).
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] OVF_DVD = (XLEN == 32) ? XLEN'(DIV_OVF_DIVIDEND)
                                                       : {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   orig_q, orig_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              sel_rem_q, sel_rem_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept_s;
    logic              signed_s;
    logic              div0_s;
    logic              ovf_s;
    logic [XLEN-1:0]   dvd_abs_s;
    logic [XLEN-1:0]   dvs_abs_s;
    logic [XLEN-1:0]   step_rem_s;
    logic [XLEN-1:0]   step_quo_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_result_s;
`ifdef DIV_FASTPATH_EN
    logic              special_s;
`endif

    // RISC-V mandated results for the two special cases: x/0 and MIN/-1.
    function automatic logic [XLEN-1:0] override_result(input logic            div0,
                                                        input logic            sel_rem,
                                                        input logic [XLEN-1:0] dvd);
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        if (div0) begin
            q = ALL_ONES;
            r = dvd;
        end else begin
            q = OVF_DVD;
            r = {XLEN{1'b0}};
        end
        override_result = sel_rem ? r : q;
    endfunction

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem_s),
        .quo_o (step_quo_s)
    );

    // Operand decode in IDLE: magnitudes, special-case detection and the accept condition.
    always_comb begin
        accept_s  = (state_q == IDLE) && start && !flush;
        signed_s  = is_signed_op(func3);
        div0_s    = (divisor == {XLEN{1'b0}});
        ovf_s     = signed_s && (dividend == OVF_DVD) && (divisor == ALL_ONES);
        // -MIN wraps to MIN, which is still the correct unsigned magnitude.
        dvd_abs_s = (signed_s && dividend[XLEN-1]) ? -dividend : dividend;
        dvs_abs_s = (signed_s && divisor[XLEN-1])  ? -divisor  : divisor;
`ifdef DIV_FASTPATH_EN
        special_s = div0_s || ovf_s;
`endif
    end

    // Sign restoration and override selection used in FIX.
    always_comb begin
        quo_fix_s = qneg_q ? -quo_q : quo_q;
        rem_fix_s = rneg_q ? -rem_q : rem_q;
        if (div0_q || ovf_q) begin
            fix_result_s = override_result(div0_q, sel_rem_q, orig_q);
        end else begin
            fix_result_s = sel_rem_q ? rem_fix_s : quo_fix_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; flush returns to IDLE from any busy/done state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
`ifdef DIV_FASTPATH_EN
                    state_d = special_s ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; flush masks both the stall request and the done pulse.
    always_comb begin
        busy = accept_s || (((state_q == CALC) || (state_q == FIX)) && !flush);
        done = (state_q == DONE) && !flush;
    end

    // Datapath next-state: operand latch, iteration, and result update.
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        orig_d    = orig_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cnt_d     = CNT_W'(XLEN - 1);
                    quo_d     = dvd_abs_s;
                    rem_d     = {XLEN{1'b0}};
                    dvs_d     = dvs_abs_s;
                    orig_d    = dividend;
                    qneg_d    = signed_s && (dividend[XLEN-1] ^ divisor[XLEN-1]) && !div0_s;
                    rneg_d    = signed_s && dividend[XLEN-1];
                    sel_rem_d = func3[1];
                    div0_d    = div0_s;
                    ovf_d     = ovf_s;
`ifdef DIV_FASTPATH_EN
                    if (special_s) begin
                        result_d = override_result(div0_s, func3[1], dividend);
                    end else begin
                        result_d = result_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CALC: begin
                if (!flush) begin
                    quo_d = step_quo_s;
                    rem_d = step_rem_s;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FIX: begin
                if (!flush) begin
                    result_d = fix_result_s;
                end else begin
                    result_d = result_q;
                end
            end
            DONE:    result_d = result_q;
            default: result_d = result_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            quo_q     <= {XLEN{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            orig_q    <= {XLEN{1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= {XLEN{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            orig_q    <= orig_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Self-checking bench for div_sequencer: directed RV32M cases, special
// operands, flush, asynchronous reset and back-to-back random operations,
// with expected results queued when an op is issued and popped on done.
module tb_div_sequencer;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic        flush    = 1'b0;
    logic [2:0]  func3    = 3'b000;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor  = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_res = 32'd0;

`ifdef DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int NORMAL_LAT = 34;

    div_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .func3    (func3),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Reference RISC-V divide semantics.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101:  ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  ref_result = (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: ref_result = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        if ((b == 32'd0) || (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
            exp_lat = SPECIAL_LAT;
        else
            exp_lat = NORMAL_LAT;
    endfunction

    // Issues one op (caller is just after a negedge), then waits for done.
    // Returns done cycle (-1 on timeout), result, and number of busy cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int nbusy);
        start = 1'b1; func3 = f3; dividend = a; divisor = b;
        #1;
        nbusy = busy ? 1 : 0;
        lat   = -1;
        res   = 32'd0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; func3 = 3'b100;
                dividend = $urandom; divisor = $urandom;
            end
            #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    endtask

    task automatic test_unsigned();
        logic [2:0]  f3s  [2] = '{3'b101, 3'b111};
        logic [31:0] exps [2] = '{32'd14, 32'd2};
        int lat, nbusy; logic [31:0] res; exp_t e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{exps[i], NORMAL_LAT});
            @(negedge clk);
            run_op(f3s[i], 32'd100, 32'd7, lat, res, nbusy);
            e = exp_q.pop_front();
            n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL unsigned_result[%0d]: got %h expected %h", i, res, e.res); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL unsigned_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL unsigned_busy[%0d]: got %0d expected %0d", i, nbusy, e.lat); end
            last_res = e.res;
        end
    endtask

    task automatic test_signed();
        logic [2:0]  f3s  [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as   [4] = '{-32'sd7, -32'sd7, 32'd7, 32'd7};
        logic [31:0] bs   [4] = '{32'd2, 32'd2, -32'sd2, -32'sd2};
        logic [31:0] exps [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        int lat, nbusy; logic [31:0] res; exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{exps[i], NORMAL_LAT});
            @(negedge clk);
            run_op(f3s[i], as[i], bs[i], lat, res, nbusy);
            e = exp_q.pop_front();
            n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, e.res); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL signed_busy[%0d]: got %0d expected %0d", i, nbusy, e.lat); end
            last_res = e.res;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s  [6] = '{3'b100, 3'b111, 3'b110, 3'b100, 3'b110, 3'b101};
        logic [31:0] as   [6] = '{32'd5, 32'd5, -32'sd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'd0};
        int          lats [6] = '{SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, NORMAL_LAT};
        int lat, nbusy; logic [31:0] res; exp_t e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{exps[i], lats[i]});
            @(negedge clk);
            run_op(f3s[i], as[i], bs[i], lat, res, nbusy);
            e = exp_q.pop_front();
            n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, e.res); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL special_busy[%0d]: got %0d expected %0d", i, nbusy, e.lat); end
            last_res = e.res;
        end
    endtask

    task automatic test_flush();
        int lat, nbusy; logic [31:0] res; exp_t e;
        @(negedge clk);
        start = 1'b1; func3 = 3'b101; dividend = 32'd50; divisor = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        flush = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_masked: got %b expected 0", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", done); end
        n_checks++; if (result !== last_res) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", result, last_res); end
        exp_q.push_back('{32'd3, NORMAL_LAT});
        run_op(3'b101, 32'd9, 32'd3, lat, res, nbusy);
        e = exp_q.pop_front();
        n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL flush_next_result: got %h expected %h", res, e.res); end
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL flush_next_busy: got %0d expected %0d", nbusy, e.lat); end
        last_res = e.res;
    endtask

    task automatic test_async_reset();
        int lat, nbusy; logic [31:0] res; exp_t e;
        @(negedge clk);
        start = 1'b1; func3 = 3'b101; dividend = 32'd200; divisor = 32'd3;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_rst_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL async_rst_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back('{32'd1, NORMAL_LAT});
        run_op(3'b101, 32'd1, 32'd1, lat, res, nbusy);
        e = exp_q.pop_front();
        n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL post_rst_result: got %h expected %h", res, e.res); end
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL post_rst_busy: got %0d expected %0d", nbusy, e.lat); end
        last_res = e.res;
    endtask

    task automatic test_back_to_back();
        int lat, nbusy; logic [31:0] res; exp_t e;
        logic [2:0] f3; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            exp_q.push_back('{ref_result(f3, a, b), exp_lat(f3, a, b)});
            @(negedge clk);
            run_op(f3, a, b, lat, res, nbusy);
            e = exp_q.pop_front();
            n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL b2b_result[%0d] f3=%b a=%h b=%h: got %h expected %h", i, f3, a, b, res, e.res); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_checks++; if (nbusy !== e.lat) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %0d expected %0d", i, nbusy, e.lat); end
            last_res = e.res;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
